// File: rtl/rng_dist.sv
// rng_dist: buffers SHAKE256 squeeze words in a small FIFO and hands them out
// to per-channel holding registers. Each cycle, at most one eligible channel
// is refilled, picked round-robin.
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         synchronous reset, active HIGH (despite the name)
//   flush         synchronous discard of all buffered randomness (reseed)
//   src_valid     squeeze word present on src_data
//   src_data      squeeze word, W bits
//   src_ready     FIFO can accept a word this cycle
//   ch_extract    per-channel: consumer takes its current word this cycle
//   ch_rng_valid  per-channel holding register full
//   ch_rng        per-channel word, channel i at [i*W +: W]
//   fifo_count    FIFO occupancy
//   err_underflow sticky: extract seen on an empty channel (cleared by reset only)
module rng_dist #(
    parameter int NUM_CH = 4,
    parameter int W      = 128,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       src_valid,
    input  logic [W-1:0]               src_data,
    output logic                       src_ready,
    input  logic [NUM_CH-1:0]          ch_extract,
    output logic [NUM_CH-1:0]          ch_rng_valid,
    output logic [NUM_CH*W-1:0]        ch_rng,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [W-1:0]        mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count_q;
    logic [PW-1:0]       rr_q;
    logic [NUM_CH-1:0]   valid_q;
    logic [W-1:0]        rng_q [NUM_CH];
    logic                err_q;

    logic                push;
    logic                pop;
    logic [NUM_CH-1:0]   eligible;
    logic                grant_found;
    logic [PW-1:0]       grant_idx;
    logic [PW:0]         cand_sum;
    logic [PW-1:0]       rr_next;

    // Registered-state-only ready, so a pop in the same cycle never lets a
    // push into a full FIFO through.
    assign src_ready = (count_q < CW'(DEPTH));
    assign push      = src_valid & src_ready & ~flush & ~rst_n;

    // A channel being extracted this cycle may be refilled in the same cycle,
    // which keeps its valid high with no bubble.
    assign eligible  = ~valid_q | ch_extract;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_sum = {1'b0, rr_q} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(NUM_CH)) begin
                cand_sum = cand_sum - (PW+1)'(NUM_CH);
            end
            if (!grant_found && eligible[cand_sum[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[PW-1:0];
            end
        end
    end

    assign pop = grant_found & (count_q != '0) & ~flush & ~rst_n;

    always_comb begin
        rr_next = rr_q;
        if (pop) begin
            if (grant_idx == PW'(NUM_CH - 1)) begin
                rr_next = '0;
            end else begin
                rr_next = grant_idx + PW'(1);
            end
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            rr_q    <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                rng_q[i] <= '0;
            end
        end else begin
            // Underflow is recorded even during a flush and survives it.
            if (|(ch_extract & ~valid_q)) begin
                err_q <= 1'b1;
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                rr_q    <= '0;
                valid_q <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    rng_q[i] <= '0;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                rr_q <= rr_next;
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
                for (int i = 0; i < NUM_CH; i++) begin
                    if (pop && (grant_idx == PW'(i))) begin
                        rng_q[i]   <= mem[rd_ptr];
                        valid_q[i] <= 1'b1;
                    end else if (ch_extract[i] && valid_q[i]) begin
                        rng_q[i]   <= '0;
                        valid_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign ch_rng[g*W +: W] = rng_q[g];
    end

    assign ch_rng_valid  = valid_q;
    assign fifo_count    = count_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_rng_dist.sv
// Testbench for rng_dist (NUM_CH=4, W=128, DEPTH=4): a directed vector table
// for the ordering / full / zero-bubble / round-robin / flush / underflow
// cases, then randomized traffic compared against a queue-based model.
module tb_rng_dist;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         src_valid;
    logic [127:0] src_data;
    logic         src_ready;
    logic [3:0]   ch_extract;
    logic [3:0]   ch_rng_valid;
    logic [511:0] ch_rng;
    logic [2:0]   fifo_count;
    logic         err_underflow;

    int n_pass = 0;
    int n_total = 0;

    rng_dist #(.NUM_CH(4), .W(128), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .ch_extract    (ch_extract),
        .ch_rng_valid  (ch_rng_valid),
        .ch_rng        (ch_rng),
        .fifo_count    (fifo_count),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue for the FIFO, plain arrays for the channels.
    logic [127:0] mq[$];
    logic [3:0]   m_valid;
    logic [127:0] m_word [4];
    int           m_rr;
    logic         m_err;

    task automatic model_reset();
        mq.delete();
        m_valid = 4'b0000;
        for (int i = 0; i < 4; i++) m_word[i] = '0;
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    task automatic model_update(input logic r, input logic f, input logic sv,
                                input logic [127:0] d, input logic [3:0] ex);
        bit   can_push;
        int   g;
        logic [127:0] head;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) if (ex[i] && !m_valid[i]) m_err = 1'b1;
        if (f) begin
            mq.delete();
            m_valid = 4'b0000;
            for (int i = 0; i < 4; i++) m_word[i] = '0;
            m_rr = 0;
            return;
        end
        can_push = (mq.size() < 4);
        g = -1;
        if (mq.size() > 0) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_rr + k) % 4;
                if (g < 0 && (!m_valid[c] || ex[c])) g = c;
            end
        end
        head = '0;
        if (g >= 0) begin
            head = mq.pop_front();
            m_rr = (g + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == g) begin
                m_word[i]  = head;
                m_valid[i] = 1'b1;
            end else if (ex[i] && m_valid[i]) begin
                m_word[i]  = '0;
                m_valid[i] = 1'b0;
            end
        end
        if (sv && can_push) mq.push_back(d);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic f, input logic sv,
                        input logic [127:0] d, input logic [3:0] ex);
        @(negedge clk);
        rst_n      = r;
        flush      = f;
        src_valid  = sv;
        src_data   = d;
        ch_extract = ex;
        model_update(r, f, sv, d, ex);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] wd(input int n);
        logic [31:0] t;
        t = 32'hA5A5_0000 | 32'(n);
        return {t, ~t, t, ~t};
    endfunction

    typedef struct {
        logic         rst;
        logic         fl;
        logic         sv;
        logic [127:0] d;
        logic [3:0]   ex;
        logic [2:0]   cnt;
        logic [3:0]   vld;
        logic         rdy;
        logic         err;
        int           chk_ch;
        logic [127:0] chk_w;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic fl, input logic sv,
                                input int dn, input logic [3:0] ex,
                                input logic [2:0] cnt, input logic [3:0] vld,
                                input logic rdy, input logic err,
                                input int chk_ch, input int wn);
        vec_t v;
        v.rst = rst; v.fl = fl; v.sv = sv; v.d = wd(dn); v.ex = ex;
        v.cnt = cnt; v.vld = vld; v.rdy = rdy; v.err = err;
        v.chk_ch = chk_ch; v.chk_w = wd(wn);
        return v;
    endfunction

    vec_t tbl[27];

    initial begin
        // Words 1..16 stand for A..P.
        //            rst fl sv  d   ex       cnt vld      rdy err ch  word
        tbl[0]  = mk(1, 0, 0,  0, 4'b0000, 0, 4'b0000, 1, 0, -1, 0);
        tbl[1]  = mk(0, 0, 1,  1, 4'b0000, 1, 4'b0000, 1, 0, -1, 0);
        tbl[2]  = mk(0, 0, 1,  2, 4'b0000, 1, 4'b0001, 1, 0,  0, 1);
        tbl[3]  = mk(0, 0, 1,  3, 4'b0000, 1, 4'b0011, 1, 0,  1, 2);
        tbl[4]  = mk(0, 0, 1,  4, 4'b0000, 1, 4'b0111, 1, 0,  2, 3);
        tbl[5]  = mk(0, 0, 0,  0, 4'b0000, 0, 4'b1111, 1, 0,  3, 4);
        tbl[6]  = mk(0, 0, 1,  5, 4'b0000, 1, 4'b1111, 1, 0, -1, 0);
        tbl[7]  = mk(0, 0, 1,  6, 4'b0000, 2, 4'b1111, 1, 0, -1, 0);
        tbl[8]  = mk(0, 0, 1,  7, 4'b0000, 3, 4'b1111, 1, 0, -1, 0);
        tbl[9]  = mk(0, 0, 1,  8, 4'b0000, 4, 4'b1111, 0, 0, -1, 0);
        tbl[10] = mk(0, 0, 1,  9, 4'b0000, 4, 4'b1111, 0, 0, -1, 0);
        tbl[11] = mk(0, 0, 1,  9, 4'b0100, 3, 4'b1111, 1, 0,  2, 5);
        tbl[12] = mk(0, 0, 1,  9, 4'b0100, 3, 4'b1111, 1, 0,  2, 6);
        tbl[13] = mk(0, 0, 0,  0, 4'b0100, 2, 4'b1111, 1, 0,  2, 7);
        tbl[14] = mk(0, 0, 0,  0, 4'b0010, 1, 4'b1111, 1, 0,  1, 8);
        tbl[15] = mk(0, 0, 1, 10, 4'b0000, 2, 4'b1111, 1, 0, -1, 0);
        tbl[16] = mk(0, 0, 0,  0, 4'b1010, 1, 4'b1101, 1, 0,  3, 9);
        tbl[17] = mk(0, 0, 0,  0, 4'b0000, 0, 4'b1111, 1, 0,  1, 10);
        tbl[18] = mk(0, 0, 1, 11, 4'b0000, 1, 4'b1111, 1, 0, -1, 0);
        tbl[19] = mk(0, 0, 1, 12, 4'b0000, 2, 4'b1111, 1, 0, -1, 0);
        tbl[20] = mk(0, 0, 1, 13, 4'b0000, 3, 4'b1111, 1, 0, -1, 0);
        tbl[21] = mk(0, 1, 1, 14, 4'b0000, 0, 4'b0000, 1, 0, -1, 0);
        tbl[22] = mk(0, 0, 0,  0, 4'b0001, 0, 4'b0000, 1, 1, -1, 0);
        tbl[23] = mk(0, 1, 0,  0, 4'b0000, 0, 4'b0000, 1, 1, -1, 0);
        tbl[24] = mk(0, 0, 1, 16, 4'b0000, 1, 4'b0000, 1, 1, -1, 0);
        tbl[25] = mk(0, 0, 0,  0, 4'b0000, 0, 4'b0001, 1, 1,  0, 16);
        tbl[26] = mk(1, 0, 0,  0, 4'b0000, 0, 4'b0000, 1, 0, -1, 0);

        rst_n = 1'b1; flush = 1'b0; src_valid = 1'b0; src_data = '0; ch_extract = '0;
        model_reset();

        for (int r = 0; r < 27; r++) begin
            step(tbl[r].rst, tbl[r].fl, tbl[r].sv, tbl[r].d, tbl[r].ex);
            check($sformatf("row%0d fifo_count", r), 128'(fifo_count), 128'(tbl[r].cnt));
            check($sformatf("row%0d ch_rng_valid", r), 128'(ch_rng_valid), 128'(tbl[r].vld));
            check($sformatf("row%0d src_ready", r), 128'(src_ready), 128'(tbl[r].rdy));
            check($sformatf("row%0d err_underflow", r), 128'(err_underflow), 128'(tbl[r].err));
            if (tbl[r].chk_ch >= 0)
                check($sformatf("row%0d ch_rng[%0d]", r, tbl[r].chk_ch),
                      ch_rng[tbl[r].chk_ch*128 +: 128], tbl[r].chk_w);
            if (tbl[r].rst)
                for (int c = 0; c < 4; c++)
                    check($sformatf("row%0d reset ch_rng[%0d]", r, c), ch_rng[c*128 +: 128], '0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic         r, f, sv;
            logic [127:0] d;
            logic [3:0]   ex;
            r  = ($urandom_range(0, 299) == 0);
            f  = ($urandom_range(0, 39) == 0);
            sv = ($urandom_range(0, 9) < 7);
            d  = {$urandom, $urandom, $urandom, $urandom};
            ex = 4'($urandom);
            // Keep underflow rare so the sticky flag stays informative.
            for (int i = 0; i < 4; i++)
                if (!m_valid[i] && $urandom_range(0, 15) != 0) ex[i] = 1'b0;
            step(r, f, sv, d, ex);
            check("rnd fifo_count", 128'(fifo_count), 128'(mq.size()));
            check("rnd src_ready", 128'(src_ready), 128'(mq.size() < 4));
            check("rnd ch_rng_valid", 128'(ch_rng_valid), 128'(m_valid));
            check("rnd err_underflow", 128'(err_underflow), 128'(m_err));
            for (int c = 0; c < 4; c++)
                if (m_valid[c])
                    check($sformatf("rnd ch_rng[%0d]", c), ch_rng[c*128 +: 128], m_word[c]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
